int_divider: RTL and testbench

- Sequential unsigned integer divider; one quotient bit resolved per clock using the restoring shift-subtract algorithm.
- Host pulses start with dividend/divisor. The block returns quotient and remainder with a one-cycle done pulse.
- Used as a multi-cycle arithmetic unit beside a datapath or controller that polls or waits on done.

---
 rtl/int_divider_pkg.sv | 22 ++
 rtl/int_divider_step.sv | 30 +++
 rtl/int_divider.sv | 124 ++++++++++++
 tb/tb_int_divider.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package int_divider_pkg;

    // Default operand/result width
    localparam int WIDTH_DEFAULT = 16;

    // Iteration counter must be able to hold the value WIDTH itself
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an arbitrary operand width
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/int_divider_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, subtract the divisor if it fits.
module int_divider_step
    import int_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // Keep the full incoming MSB in the compare so nothing can be lost,
    // even though the kept remainder is always below the divisor.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Shift, compare and conditionally subtract
    always_comb begin
        shifted = {rem_in, bit_in};
        fits    = (shifted >= {2'b00, divisor});
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        rem_out = fits ? diff : shifted[WIDTH:0];
        q_bit   = fits;
    end

endmodule

// File: rtl/int_divider.sv
// Sequential unsigned divider, one quotient bit per clock.
// Optional build macro INT_DIVIDER_DIVZERO_FLAG_EN adds a registered
// div_by_zero output updated alongside quotient/remainder.
module int_divider
    import int_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] quotient_next, remainder_next;
    logic             done_next;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
    logic             dbz_next;
`endif

    int_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .bit_in  (quo_reg[WIDTH-1]),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Next-state and datapath updates; everything holds unless a state acts
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        divisor_next   = divisor_reg;
        quotient_next  = quotient;
        remainder_next = remainder;
        done_next      = 1'b0;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
        dbz_next       = div_by_zero;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    divisor_next = divisor;
                    quo_next     = dividend;
                    rem_next     = '0;
                    cnt_next     = CNT_W'(WIDTH);
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                rem_next = step_rem;
                quo_next = {quo_reg[WIDTH-2:0], step_q};
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                quotient_next  = quo_reg;
                remainder_next = rem_reg[WIDTH-1:0];
                done_next      = 1'b1;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
                dbz_next       = (divisor_reg == '0);
`endif
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, working and result registers; reset abandons any division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            done        <= done_next;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
            div_by_zero <= dbz_next;
`endif
        end
    end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider with a plain-arithmetic reference.
module tb_int_divider;

    localparam int W       = 16;
    localparam int LATENCY = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
    logic         div_by_zero;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Directed cases with hand-derived expectations
    logic [W-1:0] dir_a [6] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd5,  16'd0, 16'd1234};
    logic [W-1:0] dir_b [6] = '{16'd7,   16'd1,    16'hFFFF, 16'd10, 16'd3, 16'd0};
    logic [W-1:0] dir_q [6] = '{16'd14,  16'hFFFF, 16'd1,    16'd0,  16'd0, 16'hFFFF};
    logic [W-1:0] dir_r [6] = '{16'd2,   16'd0,    16'd0,    16'd5,  16'd0, 16'd1234};

    always #5 clk = ~clk;

    int_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return '1;
        return a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return a;
        return a % b;
    endfunction

    // Launch one division, scramble the operand inputs afterwards, and
    // measure cycles from the accepting edge to the done pulse.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int lat,
                           output logic dn_accept, output logic dn_after);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dn_accept = done;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 60);
        q = quotient;
        r = remainder;
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
        dz = div_by_zero;
`else
        dz = 1'b0;
`endif
        @(posedge clk);
        #1;
        dn_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (quotient !== '0) begin
            miscompares++;
            $display("FAIL reset_quotient got=%h want=%h", quotient, 16'h0);
        end
        vectors++;
        if (remainder !== '0) begin
            miscompares++;
            $display("FAIL reset_remainder got=%h want=%h", remainder, 16'h0);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got=%b want=0", done);
        end
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
        vectors++;
        if (div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dbz got=%b want=0", div_by_zero);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        $display("reset: q=%h r=%h done=%b", quotient, remainder, done);
    endtask

    task automatic test_directed();
        logic [W-1:0] q, r;
        logic dz, dn0, dn1;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_div(dir_a[i], dir_b[i], q, r, dz, lat, dn0, dn1);
            $display("directed %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", i, dir_a[i], dir_b[i], q, r, lat);
            vectors++;
            if (q !== dir_q[i]) begin
                miscompares++;
                $display("FAIL directed_q[%0d] got=%h want=%h", i, q, dir_q[i]);
            end
            vectors++;
            if (r !== dir_r[i]) begin
                miscompares++;
                $display("FAIL directed_r[%0d] got=%h want=%h", i, r, dir_r[i]);
            end
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LATENCY);
            end
            vectors++;
            if (dn0 !== 1'b0 || dn1 !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_done_pulse[%0d] got=%b%b want=00", i, dn0, dn1);
            end
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
            vectors++;
            if (dz !== (dir_b[i] == 0)) begin
                miscompares++;
                $display("FAIL directed_dbz[%0d] got=%b want=%b", i, dz, (dir_b[i] == 0));
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r;
        logic dz, dn0, dn1;
        int lat, sel;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 7);
            a   = W'($urandom);
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = W'($urandom_range(1, 255));
            else               b = W'($urandom);
            run_div(a, b, q, r, dz, lat, dn0, dn1);
            $display("random %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", i, a, b, q, r, lat);
            vectors++;
            if (q !== ref_q(a, b) || r !== ref_r(a, b)) begin
                miscompares++;
                $display("FAIL random_result[%0d] got=%h/%h want=%h/%h", i, q, r, ref_q(a, b), ref_r(a, b));
            end
            vectors++;
            if (lat !== LATENCY || dn0 !== 1'b0 || dn1 !== 1'b0) begin
                miscompares++;
                $display("FAIL random_timing[%0d] got lat=%0d pre=%b post=%b want lat=%0d pre=0 post=0",
                         i, lat, dn0, dn1, LATENCY);
            end
`ifdef INT_DIVIDER_DIVZERO_FLAG_EN
            vectors++;
            if (dz !== (b == 0)) begin
                miscompares++;
                $display("FAIL random_dbz[%0d] got=%b want=%b", i, dz, (b == 0));
            end
`endif
        end
    endtask

    // Start stays high at every IDLE edge and toggles randomly while busy,
    // with operand inputs scrambled after each acceptance.
    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int lat;
        a = W'($urandom);
        b = W'($urandom_range(1, 4000));
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_done_at_accept[%0d] got=%b want=0", k, done);
            end
            lat = 0;
            do begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                start    = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                lat++;
            end while (!done && lat < 60);
            $display("b2b %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", k, a, b, quotient, remainder, lat);
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d] got=%0d want=%0d", k, lat, LATENCY);
            end
            vectors++;
            if (quotient !== ref_q(a, b) || remainder !== ref_r(a, b)) begin
                miscompares++;
                $display("FAIL b2b_result[%0d] got=%h/%h want=%h/%h", k, quotient, remainder, ref_q(a, b), ref_r(a, b));
            end
            a = W'($urandom);
            b = W'($urandom_range(0, 3000));
            dividend = a;
            divisor  = b;
            start    = (k < 9);
            @(posedge clk);
            #1;
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_final_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_midop_reset();
        logic [W-1:0] q, r;
        logic dz, dn0, dn1, seen;
        int lat;
        run_div(16'd1000, 16'd3, q, r, dz, lat, dn0, dn1);
        vectors++;
        if (q !== 16'd333 || r !== 16'd1) begin
            miscompares++;
            $display("FAIL pre_reset_result got=%h/%h want=%h/%h", q, r, 16'd333, 16'd1);
        end
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (quotient !== '0 || remainder !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs got=%h/%h/%b want=0000/0000/0", quotient, remainder, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_no_done got=%b want=0", seen);
        end
        run_div(16'd50000, 16'd123, q, r, dz, lat, dn0, dn1);
        $display("after reset: 50000 / 123 -> q=%0d r=%0d lat=%0d", q, r, lat);
        vectors++;
        if (q !== 16'd406 || r !== 16'd62 || lat !== LATENCY) begin
            miscompares++;
            $display("FAIL post_reset_div got=%0d/%0d lat=%0d want=406/62 lat=%0d", q, r, lat, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
